// File: rtl/pipeline_ctrl_if.sv
// Hazard inputs and stall/flush controls exchanged between the RV32 datapath and
// the pipeline sequencing controller.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       RdE;
    logic             ResultSrcE0;
    logic             PCSrcE;
    logic             MdStartE;
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             FlushD;
    logic             FlushE;
    logic             FlushM;
    logic             MdBusy;
    logic             MdDone;
    logic [CNT_W-1:0] StallCount;

    // Datapath side: presents hazard information, consumes stall/flush enables.
    modport master (
        output Rs1D, Rs2D, RdE, ResultSrcE0, PCSrcE, MdStartE,
        input  StallF, StallD, StallE, FlushD, FlushE, FlushM,
        input  MdBusy, MdDone, StallCount
    );

    // Controller side.
    modport slave (
        input  Rs1D, Rs2D, RdE, ResultSrcE0, PCSrcE, MdStartE,
        output StallF, StallD, StallE, FlushD, FlushE, FlushM,
        output MdBusy, MdDone, StallCount
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencing for the 5-stage RV32 pipeline: load-use hazards, taken
// branches resolved in E, and a multi-cycle mul/div unit that holds E for MD_LAT cycles.
module pipeline_ctrl #(
    parameter int MD_LAT = 4,
    parameter int CNT_W  = 32
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0]       CNT_INIT  = 4'(MD_LAT - 2);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cnt_q;
    logic [3:0]       cnt_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] stall_count_d;

    logic lw_hit;
    logic lw_stall;
    logic md_trig;
    logic md_hold;
    logic stall_f;
    logic flush_d;
    logic flush_e;
    logic md_done;

    // Hazard detection and stall/flush priority: mul/div hold > branch > load-use.
    always_comb begin
        lw_hit   = bus.ResultSrcE0 & (bus.RdE != 5'd0) &
                   ((bus.RdE == bus.Rs1D) | (bus.RdE == bus.Rs2D));
        lw_stall = lw_hit & (state_q != BUSY);
        md_trig  = (state_q == RUN) & bus.MdStartE;
        md_hold  = md_trig | (state_q == BUSY);
        stall_f  = (lw_stall & ~bus.PCSrcE) | md_hold;
        flush_d  = bus.PCSrcE & ~md_hold;
        flush_e  = (lw_stall | bus.PCSrcE) & ~md_hold;
        md_done  = (state_q == DONE);
    end

    // Mul/div sequencer: RUN -> (BUSY) -> DONE -> RUN, counting the extra hold cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RUN: begin
                if (md_trig) begin
                    cnt_d   = CNT_INIT;
                    state_d = (MD_LAT == 2) ? DONE : BUSY;
                end else begin
                    state_d = RUN;
                end
            end
            BUSY: begin
                // A corrupted zero count also exits rather than wrapping through 15.
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                state_d = RUN;
            end
            default: begin
                state_d = RUN;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Saturating count of cycles in which fetch is held.
    always_comb begin
        if (stall_f && (stall_count_q != CNT_MAX)) begin
            stall_count_d = stall_count_q + CNT_ONE;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= RUN;
            cnt_q         <= 4'd0;
            stall_count_q <= CNT_ZERO;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    // Outputs are same-cycle decodes; all of them are held low while reset is asserted.
    assign bus.StallF     = rst & stall_f;
    assign bus.StallD     = rst & stall_f;
    assign bus.StallE     = rst & md_hold;
    assign bus.FlushD     = rst & flush_d;
    assign bus.FlushE     = rst & flush_e;
    assign bus.FlushM     = rst & md_hold;
    assign bus.MdBusy     = rst & md_hold;
    assign bus.MdDone     = rst & md_done;
    assign bus.StallCount = rst ? stall_count_q : CNT_ZERO;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expected outputs, a
// negedge monitor pops and compares. dut_a: MD_LAT=4/CNT_W=32, dut_b: MD_LAT=2/CNT_W=4.
module tb_pipeline_ctrl;

    // Expected control vector bit order:
    // {StallF, StallD, StallE, FlushD, FlushE, FlushM, MdBusy, MdDone}
    localparam logic [7:0] C_IDLE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BR   = 8'b0001_1000;
    localparam logic [7:0] C_MD   = 8'b1110_0110;
    localparam logic [7:0] C_DN   = 8'b0000_0001;

    typedef struct {
        bit          sel_b;
        logic [7:0]  ctl;
        logic [31:0] cnt;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   tests    = 0;
    int   failures = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    pipeline_ctrl_if #(.CNT_W(32)) bus_a ();
    pipeline_ctrl_if #(.CNT_W(4))  bus_b ();

    pipeline_ctrl #(.MD_LAT(4), .CNT_W(32)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pipeline_ctrl #(.MD_LAT(2), .CNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    task automatic zero_inputs();
        bus_a.Rs1D = 5'd0; bus_a.Rs2D = 5'd0; bus_a.RdE = 5'd0;
        bus_a.ResultSrcE0 = 1'b0; bus_a.PCSrcE = 1'b0; bus_a.MdStartE = 1'b0;
        bus_b.Rs1D = 5'd0; bus_b.Rs2D = 5'd0; bus_b.RdE = 5'd0;
        bus_b.ResultSrcE0 = 1'b0; bus_b.PCSrcE = 1'b0; bus_b.MdStartE = 1'b0;
    endtask

    // One cycle of stimulus on the selected DUT plus its expected response.
    task automatic drive(input bit sel_b, input logic r,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rde,
                         input logic ld, input logic pc, input logic md,
                         input logic [7:0] ctl, input logic [31:0] cnt, input string name);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        zero_inputs();
        if (sel_b) begin
            bus_b.Rs1D = rs1; bus_b.Rs2D = rs2; bus_b.RdE = rde;
            bus_b.ResultSrcE0 = ld; bus_b.PCSrcE = pc; bus_b.MdStartE = md;
        end else begin
            bus_a.Rs1D = rs1; bus_a.Rs2D = rs2; bus_a.RdE = rde;
            bus_a.ResultSrcE0 = ld; bus_a.PCSrcE = pc; bus_a.MdStartE = md;
        end
        e.sel_b = sel_b;
        e.ctl   = ctl;
        e.cnt   = cnt;
        e.name  = name;
        sb.push_back(e);
    endtask

    // Monitor: compares the DUT outputs against the oldest pending expectation.
    initial begin
        exp_t        e;
        logic [7:0]  act_ctl;
        logic [31:0] act_cnt;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel_b) begin
                    act_ctl = {bus_b.StallF, bus_b.StallD, bus_b.StallE, bus_b.FlushD,
                               bus_b.FlushE, bus_b.FlushM, bus_b.MdBusy, bus_b.MdDone};
                    act_cnt = {28'd0, bus_b.StallCount};
                end else begin
                    act_ctl = {bus_a.StallF, bus_a.StallD, bus_a.StallE, bus_a.FlushD,
                               bus_a.FlushE, bus_a.FlushM, bus_a.MdBusy, bus_a.MdDone};
                    act_cnt = bus_a.StallCount;
                end
                tests++;
                if ((act_ctl !== e.ctl) || (act_cnt !== e.cnt)) begin
                    failures++;
                    $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                             e.name, act_ctl, act_cnt, e.ctl, e.cnt);
                end
            end
        end
    end

    initial begin
        logic [7:0]  b2b_ctl [8];
        logic [31:0] b2b_cnt [8];
        b2b_ctl = '{C_MD, C_MD, C_MD, C_DN, C_MD, C_MD, C_MD, C_DN};
        b2b_cnt = '{32'd8, 32'd9, 32'd10, 32'd11, 32'd11, 32'd12, 32'd13, 32'd14};

        rst = 1'b0;
        zero_inputs();

        // Reset behaviour: outputs forced low even with hazards and mul/div asserted.
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd0, "reset");
        drive(1'b0, 1'b0, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, C_IDLE, 32'd0, "reset_forces_zero");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd0, "idle_after_reset");

        // Load-use, x0 load, branch priority.
        drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, C_LU,   32'd0, "loaduse_rs1");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd1, "count_after_lu");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, C_IDLE, 32'd1, "load_x0");
        drive(1'b0, 1'b1, 5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b0, C_LU,   32'd1, "loaduse_rs2");
        drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0, C_BR,   32'd2, "branch_beats_lu");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, C_BR,   32'd2, "branch_only");
        drive(1'b0, 1'b1, 5'd5, 5'd6, 5'd4, 1'b1, 1'b0, 1'b0, C_IDLE, 32'd2, "load_no_match");

        // Single MD_LAT=4 sequence.
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd2, "md_t0");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd3, "md_t1");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd4, "md_t2");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_DN,   32'd5, "md_t3_done");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd5, "md_t4_run");

        // Branch and load-use during BUSY are ignored.
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd5, "busy_ign_t0");
        drive(1'b0, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b1, 1'b1, C_MD,   32'd6, "busy_ign_t1");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd7, "busy_ign_t2");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_DN,   32'd8, "busy_ign_done");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd8, "busy_ign_run");

        // Back-to-back mul/div: MdDone at t+3 and t+7.
        for (int k = 0; k < 8; k++) begin
            drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, b2b_ctl[k], b2b_cnt[k], "b2b");
        end
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd14, "b2b_end");

        // Reset in the middle of a sequence, then the re-fetched op retriggers.
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd14, "rst_mid_t0");
        drive(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_IDLE, 32'd0,  "rst_mid_t1");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd0,  "retrig_t0");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd1,  "retrig_t1");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd2,  "retrig_t2");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_DN,   32'd3,  "retrig_done");
        drive(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd3,  "retrig_run");

        // MD_LAT=2: one stall cycle then DONE.
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_MD,   32'd0, "lat2_t0");
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, C_DN,   32'd1, "lat2_done");
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd1, "lat2_run");

        // 4-bit counter saturates at 15 across 20 load-use stall cycles.
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 1'b1, 5'd5, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0, C_LU,
                  (i + 1 > 15) ? 32'd15 : 32'(i + 1), "sat_stall");
        end
        drive(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE, 32'd15, "sat_hold");

        for (int w = 0; w < 10; w++) begin
            if (sb.size() > 0) begin
                @(negedge clk);
            end
        end
        #2;
        if (sb.size() > 0) begin
            tests++;
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Pipeline sequencing controller for the 5-stage RV32 core. Generates stall and flush enables for the F/D/E/M pipeline registers. It covers three cases: load-use hazards, taken branches/jumps resolved in E, and a multi-cycle mul/div unit that must hold its instruction in E for MD_LAT cycles. It sits beside the forwarding unit, which is unchanged. This block only decides when stages hold or bubble.

Parameters:
MD_LAT, 4, total cycles a mul/div instruction occupies E (legal range 2..16).
CNT_W, 32, width of the stall-cycle performance counter.

Ports:
clk  in  1  core clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
Rs1D  in  5  source register 1 of instruction in D
Rs2D  in  5  source register 2 of instruction in D
RdE  in  5  destination register of instruction in E
ResultSrcE0  in  1  instruction in E is a load
PCSrcE  in  1  branch/jump taken, resolved in E
MdStartE  in  1  instruction in E is a mul/div op
StallF  out  1  hold PC register
StallD  out  1  hold IF/ID register
StallE  out  1  hold ID/EX register
FlushD  out  1  clear IF/ID register
FlushE  out  1  clear ID/EX register
FlushM  out  1  clear EX/MEM register (insert bubble)
MdBusy  out  1  mul/div sequence in progress (trigger cycle or BUSY)
MdDone  out  1  mul/div result valid in E this cycle
StallCount  out  CNT_W  number of cycles with StallF=1

Behaviour:
- States: RUN, BUSY, DONE. Also a down-counter cnt, 4 bits.
- Reset (rst=0 at edge): state<=RUN, cnt<=0, StallCount<=0.
- While rst=0, every output is forced to 0.
- lwStall = ResultSrcE0 & (RdE!=0) & ((RdE==Rs1D)|(RdE==Rs2D)).
  - Evaluated only in RUN and DONE.
  - Forced 0 in BUSY.
- mdTrig = (state==RUN) & MdStartE.
  - DONE ignores MdStartE, so the same instruction does not re-trigger.
- RUN:
  - If mdTrig: cnt<=MD_LAT-2; next state = DONE if MD_LAT==2, else BUSY.
  - Otherwise stay in RUN.
- BUSY:
  - If cnt==1: next state DONE.
  - Otherwise cnt<=cnt-1.
  - PCSrcE and lwStall are ignored.
- DONE: always return to RUN next cycle. MdDone=1.
- Result: the mul/div instruction holds E for exactly MD_LAT cycles, with MD_LAT-1 stall cycles plus the DONE cycle, in which it advances.
- Output equations (combinational from state and inputs, no added latency):
  - mdHold = mdTrig | (state==BUSY)
  - StallF = StallD = (lwStall & ~PCSrcE) | mdHold
  - StallE = mdHold
  - FlushM = mdHold
  - FlushD = PCSrcE & ~mdHold
  - FlushE = (lwStall | PCSrcE) & ~mdHold
  - MdBusy = mdHold
- Priority:
  - A taken branch beats load-use: when both are asserted, StallF=StallD=0, FlushD=FlushE=1.
  - A mul/div hold beats everything.
- StallCount: increments by 1 on each edge where StallF=1 and rst=1. Saturates at all-ones (no wrap).
- Reset mid-sequence: state returns to RUN. No DONE pulse is emitted. The re-fetched instruction retriggers normally.
- Back-to-back mul/div: the second op enters E on the cycle after DONE, so mdTrig fires from RUN with no idle gap.
- A load into x0 never stalls.

Test Plan:
1. Load-use: ResultSrcE0=1, RdE=5, Rs1D=5 in RUN -> StallF=StallD=1, FlushE=1, StallE=0, StallCount +1.
2. Load into x0: RdE=0, Rs2D=0 -> no stall. Branch+load-use together (PCSrcE=1, lwStall=1) -> StallF=0, FlushD=FlushE=1.
3. Mul/div, MD_LAT=4: MdStartE=1 held from cycle t:
   - Stall/StallE/FlushM=1 at t, t+1, t+2.
   - MdDone=1 and all stalls 0 at t+3.
   - RUN at t+4. StallCount +3.
4. Ignored inputs during BUSY: PCSrcE=1 and load-use pattern at t+1 -> FlushD=FlushE=0; outputs identical to scenario 3.
5. Sequencing edge cases:
   - Back-to-back ops (MdStartE held for 8 cycles) -> two full 4-cycle sequences, MdDone at t+3 and t+7.
   - MD_LAT=2 -> a single stall cycle, then DONE.
6. Reset and saturation:
   - rst=0 at t+1 of a sequence -> all outputs 0 during reset. After release, RUN with StallCount=0.
   - With CNT_W=4, 20 stall cycles -> StallCount holds 15.
